fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset (word-aligned).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port imem_addr  output  XLEN  fetch address to a combinational instruction memory.
REQ-007 The block SHALL have port imem_instr  input  XLEN  instruction word returned for imem_addr in the same cycle.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc  input  XLEN  redirect target address.
REQ-010 The block SHALL have port out_valid  output  1  head entry valid to decode.
REQ-011 The block SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-012 The block SHALL have port out_pc  output  XLEN  PC of the head entry.
REQ-013 The block SHALL have port out_pc4  output  XLEN  out_pc + 4, modulo 2^XLEN.
REQ-014 The block SHALL have port out_instr  output  XLEN  instruction of the head entry.
REQ-015 The block SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 The block SHALL drive imem_addr from the fetch PC register fpc at all times, including during reset.
REQ-017 The block SHALL define deq = out_valid && out_ready, and full = (count == DEPTH).
REQ-018 The block SHALL define enq = !reset && !redirect_valid && (!full || deq).
REQ-019 On enq, the block SHALL write {fpc, imem_instr} into the tail entry, advance the tail pointer modulo DEPTH and set fpc <= fpc + 4 modulo 2^XLEN.
REQ-020 On deq, the block SHALL advance the head pointer modulo DEPTH.
REQ-021 The block SHALL update count as follows: +1 on enq only, -1 on deq only, and unchanged when enq and deq occur together.
REQ-022 When full and deq occur in the same cycle, the block SHALL both enqueue and dequeue, leaving count at DEPTH.
REQ-023 The block SHALL make an enqueued entry visible at the outputs no earlier than the cycle after its enq (one-cycle fetch-to-decode latency).
REQ-024 The block SHALL present the head entry (first-word-fall-through) whenever count > 0, with out_valid = (count != 0).
REQ-025 The block SHALL hold out_pc, out_pc4 and out_instr stable while out_valid && !out_ready.
REQ-026 On redirect_valid, the block SHALL flush the queue in the next cycle (count <= 0, head <= tail) and set fpc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-027 On redirect_valid, the block SHALL perform no enqueue that cycle; any deq in the same cycle completes normally (decode consumed the entry) and is then discarded by the flush.
REQ-028 In the cycle after a redirect, the block SHALL show out_valid = 0 and fetch from the redirect target.
REQ-029 When redirect_valid is asserted on consecutive cycles, the block SHALL let the last redirect determine fpc.
REQ-030 The block SHALL wrap fpc from 2^XLEN-4 to 0 without error.
REQ-031 When out_valid = 0, out_pc, out_pc4 and out_instr are don't-care; the block SHALL NOT generate any X on out_valid or count.

Reset
REQ-032 While reset is high, the block SHALL set fpc <= RESET_PC, head <= 0, tail <= 0, count <= 0 and out_valid = 0 on the next edge.
REQ-033 Reset SHALL take priority over redirect_valid and over any enq or deq in the same cycle.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; the first enq occurs in the first cycle with reset low.
REQ-035 Queue storage contents SHALL NOT require reset.

Verification
REQ-036 Basic streaming: reset, then out_ready=1 and imem returns 0x00000013 for every address -> out_valid rises 1 cycle after the first fetch; out_pc sequence 0,4,8,...; out_pc4 = out_pc+4.
REQ-037 Backpressure and full: out_ready=0, DEPTH=4 -> count reaches 4, fpc stops at 0x10 and the head stays at pc 0; raising out_ready with count=4 -> enq and deq together, count stays 4, pcs continue in order with none lost.
REQ-038 Redirect: redirect_valid=1 with redirect_pc=0x00000103 while count=3 -> next cycle count=0 and out_valid=0; imem_addr=0x100; the following out_pc is 0x100.
REQ-039 Redirect plus deq: redirect asserted while out_valid && out_ready -> head consumed once; no stale entry is presented afterwards.
REQ-040 Wrap: RESET_PC=0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; out_pc4 for 0xFFFFFFFC equals 0x0.
REQ-041 Reset mid-stream: reset pulsed while count=2 -> next cycle count=0, out_valid=0 and imem_addr=RESET_PC; reset has priority over a simultaneous redirect.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC generator feeding a small FIFO to decode.
// Head entry falls through; redirects flush and retarget the fetch PC.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_instr,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc4,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic deq;
    logic full;
    logic enq;
    logic [1:0] redir_unused;

    assign redir_unused = redirect_pc[1:0];

    assign imem_addr = fpc_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_q[head_q];
    assign out_pc4   = pc_q[head_q] + XLEN'(4);
    assign out_instr = instr_q[head_q];

    assign deq  = out_valid && out_ready;
    assign full = (count_q == CW'(DEPTH));
    assign enq  = !reset && !redirect_valid && (!full || deq);

    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            // Any same-cycle deq is absorbed by the flush.
            fpc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + AW'(1);
                fpc_d  = fpc_q + XLEN'(4);
            end
            if (deq) begin
                head_d = head_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[tail_q]    <= fpc_q;
            instr_q[tail_q] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirect,
// reset priority and PC wrap, all with hand-computed expectations.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    logic        rst_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_instr_w;
    logic        out_valid_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_pc4_w;
    logic [31:0] out_instr_w;
    logic [2:0]  count_w;

    int n_vec;
    int n_bad;

    // Instruction memory returns a word that encodes its own address.
    assign imem_instr   = imem_addr ^ 32'h0000_0013;
    assign imem_instr_w = imem_addr_w ^ 32'h0000_0013;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_instr      (out_instr),
        .count          (count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .reset          (rst_w),
        .imem_addr      (imem_addr_w),
        .imem_instr     (imem_instr_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (out_valid_w),
        .out_ready      (1'b1),
        .out_pc         (out_pc_w),
        .out_pc4        (out_pc4_w),
        .out_instr      (out_instr_w),
        .count          (count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        rst_w          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming with decode always ready.
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_pc0", out_pc, 32'h0);
        chk("st_instr0", out_instr, 32'h13);
        chk("st_addr", imem_addr, 32'h4);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("st_pc", out_pc, 32'(4 * k));
            chk("st_pc4", out_pc4, 32'(4 * k + 4));
            chk("st_instr", out_instr, 32'(4 * k) ^ 32'h13);
            chk("st_count", 32'(count), 32'd1);
        end

        // Reset mid-stream beats a simultaneous redirect.
        out_ready = 1'b0;
        tick();
        chk("mid_count2", 32'(count), 32'd2);
        chk("mid_hold", out_pc, 32'hC);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        reset          = 1'b0;
        redirect_valid = 1'b0;

        // Backpressure until full, then simultaneous enq/deq.
        tick();
        chk("bp_addr1", imem_addr, 32'h4);
        chk("bp_pc", out_pc, 32'h0);
        tick();
        tick();
        tick();
        chk("bp_full", 32'(count), 32'd4);
        chk("bp_addr", imem_addr, 32'h10);
        tick();
        chk("bp_stay", 32'(count), 32'd4);
        chk("bp_fpc", imem_addr, 32'h10);
        chk("bp_head", out_pc, 32'h0);
        chk("bp_hinstr", out_instr, 32'h13);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fd_pc", out_pc, 32'(4 * k));
            chk("fd_count", 32'(count), 32'd4);
            chk("fd_addr", imem_addr, 32'(16 + 4 * k));
        end

        // Redirect during a dequeue: no stale entry afterwards.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        chk("rd_count", 32'(count), 32'd0);
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_addr", imem_addr, 32'h80);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        chk("rd_next", out_pc, 32'h80);
        chk("rd_ninstr", out_instr, 32'h93);
        tick();
        tick();
        chk("rd_cnt3", 32'(count), 32'd3);

        // Unaligned redirect target at count 3.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        chk("r3_count", 32'(count), 32'd0);
        chk("r3_valid", 32'(out_valid), 32'd0);
        chk("r3_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        chk("r3_pc", out_pc, 32'h100);
        chk("r3_pc4", out_pc4, 32'h104);
        tick();
        chk("r3_pc2", out_pc, 32'h104);

        // Back-to-back redirects: the last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        redirect_pc = 32'h10B;
        tick();
        chk("rr_addr", imem_addr, 32'h108);
        chk("rr_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("rr_pc", out_pc, 32'h108);

        // Fetch PC wrap on the second instance.
        chk("wr_raddr", imem_addr_w, 32'hFFFF_FFF8);
        rst_w = 1'b0;
        tick();
        chk("wr_pc0", out_pc_w, 32'hFFFF_FFF8);
        chk("wr_pc40", out_pc4_w, 32'hFFFF_FFFC);
        tick();
        chk("wr_pc1", out_pc_w, 32'hFFFF_FFFC);
        chk("wr_pc41", out_pc4_w, 32'h0);
        tick();
        chk("wr_pc2", out_pc_w, 32'h0);
        chk("wr_instr2", out_instr_w, 32'h13);
        chk("wr_count", 32'(count_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
